// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, mid-bit sampling FSM, per-frame status strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 parityError,
    output logic                 busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rxIn};
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    // A start bit that is gone by mid-bit is line noise.
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    par_d     = rx_s;
                    state_d   = StStop;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shreg_q, par_q};
`endif
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold off until the line goes high so a break does not retrigger.
                clk_cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    assign dataOut    = data_q;
    assign dataValid  = valid_q;
    assign frameError = ferr_q;
    assign busy       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parityError = perr_q;
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, 8 data bits.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;
    localparam int unsigned DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam int FRAME = (DB + 2 + PEN) * CPB;
    localparam int LAT   = 2 + CPB / 2 + (DB + 1 + PEN) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [DB-1:0] dataOut;
    logic          dataValid, frameError, parityError, busy;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxIn       (rx),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .frameError (frameError),
        .parityError(parityError),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc = 0;
    logic clr_max = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    int          n_valid = 0, n_ferr = 0, n_perr = 0, n_perr_alone = 0, busy_bad = 0;
    int          busy_run = 0, max_busy = 0;
    logic        busy_prev = 1'b0;
    logic [7:0]  vals[$];
    int          vcyc[$];

    always @(negedge clk) begin
        if (clr_max) max_busy = 0;
        if (dataValid) begin
            vals.push_back(dataOut);
            vcyc.push_back(cyc);
            n_valid++;
            if (busy || !busy_prev) busy_bad++;
        end
        if (frameError) n_ferr++;
        if (parityError) begin
            n_perr++;
            if (!dataValid) n_perr_alone++;
        end
        if (busy) begin
            busy_run++;
            if (busy_run > max_busy) max_busy = busy_run;
        end else begin
            busy_run = 0;
        end
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PEN != 0) drive_bit(par);
        drive_bit(stop);
    endtask

    function automatic logic [31:0] val_at(input int i);
        return (vals.size() > i) ? 32'(vals[i]) : 32'hdead;
    endfunction

    function automatic int cyc_at(input int i);
        return (vcyc.size() > i) ? vcyc[i] : -100000;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst dataOut", 32'(dataOut), 0);
        check("rst dataValid", 32'(dataValid), 0);
        check("rst frameError", 32'(frameError), 0);
        check("rst parityError", 32'(parityError), 0);
        check("rst busy", 32'(busy), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte
        send(8'hA5, 1'b1, ^8'hA5);
        repeat (2 * CPB) @(negedge clk);
        check("a5 count", 32'(n_valid), 1);
        check("a5 value", val_at(0), 32'hA5);
        check("a5 dataOut", 32'(dataOut), 32'hA5);
        check("a5 ferr", 32'(n_ferr), 0);
        check("a5 busy edge", 32'(busy_bad), 0);
        check("a5 latency", 32'((cyc_at(0) - start_cyc >= LAT - 1) &&
                                (cyc_at(0) - start_cyc <= LAT + 1)), 1);

        // Back to back, no idle gap
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("b2b count", 32'(n_valid), 4);
        check("b2b v0", val_at(1), 32'h00);
        check("b2b v1", val_at(2), 32'hFF);
        check("b2b v2", val_at(3), 32'h3C);
        check("b2b gap1", 32'(cyc_at(2) - cyc_at(1)), 32'(FRAME));
        check("b2b gap2", 32'(cyc_at(3) - cyc_at(2)), 32'(FRAME));

        // Start glitch
        @(posedge clk) clr_max = 1'b1;
        @(posedge clk) clr_max = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch busy seen", 32'(max_busy >= 1), 1);
        check("glitch busy len", 32'(max_busy <= 10), 1);
        check("glitch no valid", 32'(n_valid), 4);
        check("glitch no ferr", 32'(n_ferr), 0);
        check("glitch idle", 32'(busy), 0);

        // Bad stop bit, line held low
        send(8'h55, 1'b0, ^8'h55);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        check("brk ferr", 32'(n_ferr), 1);
        check("brk no valid", 32'(n_valid), 4);
        check("brk dataOut", 32'(dataOut), 32'h3C);
        check("brk busy", 32'(busy), 1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("brk released", 32'(busy), 0);
        check("brk no restart", 32'(n_valid), 4);

        // Reset during the 4th data bit of 0x81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy", 32'(busy), 0);
        check("abort dataOut", 32'(dataOut), 0);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("abort no valid", 32'(n_valid), 4);
        check("abort no ferr", 32'(n_ferr), 1);
        send(8'h81, 1'b1, ^8'h81);
        repeat (2 * CPB) @(negedge clk);
        check("after abort count", 32'(n_valid), 5);
        check("after abort data", 32'(dataOut), 32'h81);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("par ok valid", 32'(n_valid), 6);
        check("par ok perr", 32'(n_perr), 0);
        send(8'h07, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("par bad valid", 32'(n_valid), 7);
        check("par bad perr", 32'(n_perr), 1);
        check("par bad data", 32'(dataOut), 32'h07);
`else
        check("no parity pulses", 32'(n_perr), 0);
`endif
        check("perr with valid", 32'(n_perr_alone), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
